// File: rtl/msx_config_record_parser.sv
// rtl/msx_config_record_parser.sv - splits the MSX config byte stream into 12-byte records and decodes them
// Optional strict checking of padding and slot/type consistency: MSX_CFG_STRICT_EN.
module msx_config_record_parser #(
  parameter int MAX_RECORDS = 48,
  localparam int IW = (MAX_RECORDS > 1) ? $clog2(MAX_RECORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dl_start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          rec_valid,
  input  logic          rec_ready,
  output logic [3:0]    rec_typ,
  output logic [1:0]    rec_slot,
  output logic [1:0]    rec_subslot,
  output logic [3:0]    rec_data_id,
  output logic [15:0]   rec_block_count,
  output logic [1:0]    rec_start,
  output logic [7:0]    rec_mode,
  output logic [7:0]    rec_pagemap,
  output logic [7:0]    rec_param,
  output logic [IW-1:0] rec_index,
  output logic          cfg_done,
  output logic [3:0]    slot_expander_en,
  output logic          msx_typ,
  output logic [7:0]    ram_size,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, COLLECT, EMIT, DONE, ERROR} state_t;

  localparam logic [3:0] TYP_NONE   = 4'd0;
  localparam logic [3:0] TYP_CONFIG = 4'd6;
  localparam logic [IW:0] MAX_W     = (IW+1)'(MAX_RECORDS);

  state_t      state, nxt;
  logic [3:0]  cnt;
  logic [7:0]  shadow [0:10];
  logic        accept, last, strict_ok;
  logic [3:0]  typ;
  logic [IW:0] idx_inc;

  assign in_ready  = (state == COLLECT) || (state == DONE) || (state == ERROR);
  assign rec_valid = (state == EMIT);
  assign err       = (state == ERROR);
  assign accept    = in_valid && in_ready;
  assign last      = (state == COLLECT) && accept && (cnt == 4'd11);
  assign typ       = shadow[0][7:4];
  assign idx_inc   = {1'b0, rec_index} + {{IW{1'b0}}, 1'b1};

`ifdef MSX_CFG_STRICT_EN
  logic slot_ok;
  always_comb begin
    slot_ok = 1'b1;
    case (typ)
      4'd2:    slot_ok = (shadow[0][3:2] == 2'd1);
      4'd3:    slot_ok = (shadow[0][3:2] == 2'd2);
      4'd5:    slot_ok = (shadow[0][3:0] == 4'd0);
      default: slot_ok = 1'b1;
    endcase
  end
  // Byte 11 is still on the bus when the record is judged.
  assign strict_ok = slot_ok && (shadow[8] == 8'd0) && (shadow[9] == 8'd0) &&
                     (shadow[10] == 8'd0) && (in_data == 8'd0);
`else
  assign strict_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (dl_start) begin
      nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (last) begin
          if (!strict_ok)                          nxt = ERROR;
          else if (typ == TYP_CONFIG)              nxt = DONE;
          else if (typ == TYP_NONE || typ > TYP_CONFIG) nxt = ERROR;
          else                                     nxt = EMIT;
        end
        EMIT: if (rec_ready) nxt = (idx_inc == MAX_W) ? ERROR : COLLECT;
        default: nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt              <= '0;
      rec_typ          <= '0;
      rec_slot         <= '0;
      rec_subslot      <= '0;
      rec_data_id      <= '0;
      rec_block_count  <= '0;
      rec_start        <= '0;
      rec_mode         <= '0;
      rec_pagemap      <= '0;
      rec_param        <= '0;
      rec_index        <= '0;
      cfg_done         <= 1'b0;
      slot_expander_en <= '0;
      msx_typ          <= 1'b0;
      ram_size         <= '0;
      for (int i = 0; i < 11; i++) shadow[i] <= '0;
    end else if (dl_start) begin
      cnt       <= '0;
      rec_index <= '0;
      cfg_done  <= 1'b0;
    end else begin
      if (state == COLLECT && accept) begin
        cnt <= (cnt == 4'd11) ? 4'd0 : cnt + 4'd1;
        if (cnt < 4'd11) shadow[cnt] <= in_data;
      end
      if (last && nxt == EMIT) begin
        rec_typ         <= typ;
        rec_slot        <= shadow[0][3:2];
        rec_subslot     <= shadow[0][1:0];
        rec_data_id     <= shadow[1][3:0];
        rec_block_count <= {shadow[2], shadow[3]};
        rec_start       <= shadow[4][1:0];
        rec_mode        <= shadow[5];
        rec_pagemap     <= shadow[6];
        rec_param       <= shadow[7];
      end
      if (last && nxt == DONE) begin
        slot_expander_en <= shadow[1][3:0];
        msx_typ          <= shadow[1][4];
        ram_size         <= shadow[2];
        cfg_done         <= 1'b1;
      end
      // On overflow the index truncates; the ERROR state makes that visible.
      if (state == EMIT && rec_ready) rec_index <= idx_inc[IW-1:0];
    end
  end

endmodule

// File: tb/tb_msx_config_record_parser.sv
// tb/tb_msx_config_record_parser.sv - directed self-checking bench for msx_config_record_parser
module tb_msx_config_record_parser;

  logic clk = 1'b0;
  logic reset, dl_start, in_valid, rec_ready;
  logic [7:0] in_data;

  logic in_ready, rec_valid, cfg_done, msx_typ, err;
  logic [3:0] rec_typ, rec_data_id, slot_expander_en;
  logic [1:0] rec_slot, rec_subslot, rec_start;
  logic [15:0] rec_block_count;
  logic [7:0] rec_mode, rec_pagemap, rec_param, ram_size;
  logic [5:0] rec_index;

  logic m2_in_ready, m2_rec_valid, m2_cfg_done, m2_msx_typ, m2_err;
  logic [3:0] m2_rec_typ, m2_rec_data_id, m2_slot_expander_en;
  logic [1:0] m2_rec_slot, m2_rec_subslot, m2_rec_start;
  logic [15:0] m2_rec_block_count;
  logic [7:0] m2_rec_mode, m2_rec_pagemap, m2_rec_param, m2_ram_size;
  logic [0:0] m2_rec_index;

  always #5 clk = ~clk;

  msx_config_record_parser dut (
    .clk(clk), .reset(reset), .dl_start(dl_start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_typ(rec_typ),
    .rec_slot(rec_slot), .rec_subslot(rec_subslot), .rec_data_id(rec_data_id),
    .rec_block_count(rec_block_count), .rec_start(rec_start), .rec_mode(rec_mode),
    .rec_pagemap(rec_pagemap), .rec_param(rec_param), .rec_index(rec_index),
    .cfg_done(cfg_done), .slot_expander_en(slot_expander_en), .msx_typ(msx_typ),
    .ram_size(ram_size), .err(err));

  msx_config_record_parser #(.MAX_RECORDS(2)) dut_max2 (
    .clk(clk), .reset(reset), .dl_start(dl_start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(m2_in_ready), .rec_valid(m2_rec_valid), .rec_ready(rec_ready), .rec_typ(m2_rec_typ),
    .rec_slot(m2_rec_slot), .rec_subslot(m2_rec_subslot), .rec_data_id(m2_rec_data_id),
    .rec_block_count(m2_rec_block_count), .rec_start(m2_rec_start), .rec_mode(m2_rec_mode),
    .rec_pagemap(m2_rec_pagemap), .rec_param(m2_rec_param), .rec_index(m2_rec_index),
    .cfg_done(m2_cfg_done), .slot_expander_en(m2_slot_expander_en), .msx_typ(m2_msx_typ),
    .ram_size(m2_ram_size), .err(m2_err));

  typedef struct {
    logic [3:0]  typ;
    logic [1:0]  slot, sub, start;
    logic [3:0]  id;
    logic [15:0] bc;
    logic [7:0]  mode, pm, param;
    logic [5:0]  idx;
  } rec_s;

  rec_s log_q[$];
  int   m2_hs = 0;
  int   n_chk = 0, n_pass = 0;

  always @(negedge clk) begin
    if (rec_valid && rec_ready)
      log_q.push_back('{rec_typ, rec_slot, rec_subslot, rec_start, rec_data_id, rec_block_count,
                        rec_mode, rec_pagemap, rec_param, rec_index});
    if (m2_rec_valid && rec_ready) m2_hs++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [95:0] r, input int nb);
    for (int i = 0; i < nb; i++) send_byte(r[95-8*i -: 8]);
  endtask

  task automatic send_rec(input logic [95:0] r);
    send_bytes(r, 12);
  endtask

  task automatic pulse_start();
    @(negedge clk) dl_start = 1'b1;
    @(negedge clk) dl_start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  localparam logic [95:0] R_VG0 = 96'h40_00_00_02_00_00_03_00_00000000;
  localparam logic [95:0] R_VG1 = 96'h24_01_00_00_00_00_0C_00_00000000;
  localparam logic [95:0] R_VG2 = 96'h38_01_00_00_00_00_30_00_00000000;
  localparam logic [95:0] R_VG3 = 96'h4F_02_00_04_00_00_AA_E4_00000000;
  localparam logic [95:0] R_VGC = 96'h60_00_04_00_00_00_00_00_00000000;
  localparam logic [95:0] R_FDC = 96'h1B_03_00_10_01_00_00_00_00000000;
  localparam logic [95:0] R_NMC = 96'h60_18_80_00_00_00_00_00_00000000;
  localparam logic [95:0] R_B   = 96'h25_07_12_34_02_11_22_33_00000000;
  localparam logic [95:0] R_KBD = 96'h50_00_00_00_00_00_00_00_00000000;
  localparam logic [95:0] R_PAD = 96'h4C_02_00_01_00_00_FF_00_00_01_00_00;
  localparam logic [95:0] R_BAD = 96'h90_00_00_00_00_00_00_00_00000000;

  initial begin
    int base;
    logic [95:0] r;
    reset = 1'b1; dl_start = 1'b0; in_valid = 1'b0; in_data = '0; rec_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rec_valid", rec_valid, 0);
    chk("rst_rec_typ", rec_typ, 0);
    chk("rst_block_count", rec_block_count, 0);
    chk("rst_rec_index", rec_index, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_msx_typ", msx_typ, 0);
    chk("rst_slot_exp", slot_expander_en, 0);
    chk("rst_ram_size", ram_size, 0);
    chk("rst_err", err, 0);

    // Philips VG-8020
    pulse_start();
    chk("vg_in_ready", in_ready, 1);
    base = log_q.size();
    send_rec(R_VG0); send_rec(R_VG1); send_rec(R_VG2); send_rec(R_VG3); send_rec(R_VGC);
    settle();
    chk("vg_count", log_q.size() - base, 4);
    chk("vg_r3_typ", log_q[base+3].typ, 4);
    chk("vg_r3_slot", log_q[base+3].slot, 3);
    chk("vg_r3_sub", log_q[base+3].sub, 3);
    chk("vg_r3_id", log_q[base+3].id, 2);
    chk("vg_r3_bc", log_q[base+3].bc, 16'h0004);
    chk("vg_r3_pm", log_q[base+3].pm, 8'hAA);
    chk("vg_r3_param", log_q[base+3].param, 8'hE4);
    chk("vg_r3_idx", log_q[base+3].idx, 3);
    chk("vg_r1_slot", log_q[base+1].slot, 1);
    chk("vg_cfg_done", cfg_done, 1);
    chk("vg_msx_typ", msx_typ, 0);
    chk("vg_slot_exp", slot_expander_en, 0);
    chk("vg_ram_size", ram_size, 8'h04);
    chk("vg_rec_valid", rec_valid, 0);
    send_byte(8'hFF); send_byte(8'h4F); send_byte(8'h00);
    settle();
    chk("vg_pad_count", log_q.size() - base, 4);
    chk("vg_pad_in_ready", in_ready, 1);

    // NMS8250
    pulse_start();
    chk("nms_cfg_cleared", cfg_done, 0);
    chk("nms_idx_cleared", rec_index, 0);
    base = log_q.size();
    for (int i = 0; i < 11; i++) begin
      r = (i == 5) ? R_FDC : {8'h4C, 8'h02, 8'h00, 8'(i), 8'h00, 8'h00, 8'hFF, 8'h00, 32'h0};
      send_rec(r);
    end
    send_rec(R_NMC);
    settle();
    chk("nms_count", log_q.size() - base, 11);
    chk("nms_rec_index", rec_index, 11);
    chk("nms_slot_exp", slot_expander_en, 4'b1000);
    chk("nms_msx_typ", msx_typ, 1);
    chk("nms_ram_size", ram_size, 8'h80);
    chk("nms_fdc_typ", log_q[base+5].typ, 1);
    chk("nms_fdc_start", log_q[base+5].start, 1);
    chk("nms_fdc_id", log_q[base+5].id, 3);
    chk("nms_r10_bc", log_q[base+10].bc, 10);
    chk("nms_r10_idx", log_q[base+10].idx, 10);

    // Backpressure
    pulse_start();
    base = log_q.size();
    rec_ready = 1'b0;
    send_rec(R_VG3);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h25;
    repeat (20) @(negedge clk);
    chk("bp_rec_valid", rec_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_pm_stable", rec_pagemap, 8'hAA);
    chk("bp_param_stable", rec_param, 8'hE4);
    chk("bp_typ_stable", rec_typ, 4);
    rec_ready = 1'b1;
    send_rec(R_B);
    settle();
    chk("bp_count", log_q.size() - base, 2);
    chk("bp_next_typ", log_q[base+1].typ, 2);
    chk("bp_next_slot", log_q[base+1].slot, 1);
    chk("bp_next_sub", log_q[base+1].sub, 1);
    chk("bp_next_id", log_q[base+1].id, 7);
    chk("bp_next_bc", log_q[base+1].bc, 16'h1234);
    chk("bp_next_start", log_q[base+1].start, 2);
    chk("bp_next_mode", log_q[base+1].mode, 8'h11);
    chk("bp_next_pm", log_q[base+1].pm, 8'h22);
    chk("bp_next_param", log_q[base+1].param, 8'h33);
    chk("bp_next_idx", log_q[base+1].idx, 1);

    // Restart mid-record
    pulse_start();
    base = log_q.size();
    send_rec(R_VG0); send_rec(R_VG1);
    send_bytes(R_VG2, 7);
    pulse_start();
    send_rec(R_B);
    settle();
    chk("rs_count", log_q.size() - base, 3);
    chk("rs_idx", log_q[base+2].idx, 0);
    chk("rs_bc", log_q[base+2].bc, 16'h1234);

    // KBD_LAYOUT and non-zero padding
    pulse_start();
    base = log_q.size();
    send_rec(R_KBD);
    settle();
    chk("kbd_count", log_q.size() - base, 1);
    chk("kbd_typ", log_q[base].typ, 5);
    send_rec(R_PAD);
    settle();
`ifdef MSX_CFG_STRICT_EN
    chk("pad_err", err, 1);
    chk("pad_count", log_q.size() - base, 1);
`else
    chk("pad_err", err, 0);
    chk("pad_count", log_q.size() - base, 2);
`endif

    // Illegal type
    pulse_start();
    base = log_q.size();
    send_rec(R_BAD);
    settle();
    chk("bad_err", err, 1);
    chk("bad_rec_valid", rec_valid, 0);
    chk("bad_in_ready", in_ready, 1);
    chk("bad_count", log_q.size() - base, 0);
    pulse_start();
    chk("bad_err_cleared", err, 0);

    // Overflow with MAX_RECORDS = 2
    pulse_start();
    m2_hs = 0;
    send_rec(R_VG0);
    settle();
    chk("max_hs1", m2_hs, 1);
    chk("max_err_after1", m2_err, 0);
    send_rec(R_VG1);
    settle();
    chk("max_hs2", m2_hs, 2);
    chk("max_err_after2", m2_err, 1);
    send_rec(R_VG2);
    settle();
    chk("max_hs3", m2_hs, 2);
    chk("max_rec_valid", m2_rec_valid, 0);
    chk("max_main_idx", rec_index, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
